// File: rtl/param_est_mul_pkg.sv
// Shared widths, operand/product types and the round-robin pick used by the
// ParamEst shared-multiplier arbiter.
package param_est_mul_pkg;

  localparam int unsigned DIN0_W  = 16;
  localparam int unsigned DIN1_W  = 13;
  localparam int unsigned DOUT_W  = DIN0_W + DIN1_W;
  localparam int unsigned MAX_REQ = 16;
  localparam int unsigned PTR_W   = 4;

  typedef logic signed [DIN0_W-1:0] din0_t;
  typedef logic        [DIN1_W-1:0] din1_t;
  typedef logic signed [DOUT_W-1:0] dout_t;

  // One-hot grant on the first valid lane at or after ptr, wrapping modulo n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [PTR_W-1:0]   ptr,
                                                 input int unsigned        n);
    logic [MAX_REQ-1:0] gnt;
    logic               found;
    int unsigned        idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = (32'(ptr) + k) % n;
      if (k < n && !found && valid[idx[PTR_W-1:0]]) begin
        gnt[idx[PTR_W-1:0]] = 1'b1;
        found               = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/param_est_rr_arbiter.sv
// Combinational round-robin one-hot picker over N_REQ request lines.
module param_est_rr_arbiter
  import param_est_mul_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt_c
);

  assign gnt_c = N_REQ'(rr_pick(MAX_REQ'(valid), PTR_W'(ptr), N_REQ));

endmodule

// File: rtl/param_est_mul_share_arb.sv
// Round-robin time-sharing of one signed-16 x unsigned-13 multiplier between
// N_REQ dense-layer lanes, with a single registered, tagged result port.
module param_est_mul_share_arb
  import param_est_mul_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*DIN0_W-1:0]    req_din0,
  input  logic [N_REQ*DIN1_W-1:0]    req_din1,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic signed [DOUT_W-1:0]   res_dout,
  output logic [ID_W-1:0]            res_id,
  output logic [31:0]                op_count
);

  logic [ID_W-1:0]  rr_ptr;
  logic             can_issue_c;
  logic [N_REQ-1:0] pick_c;
  logic             gnt_any_c;
  logic [ID_W-1:0]  gnt_id_c;
  din0_t            op0_c;
  din1_t            op1_c;
  dout_t            prod_c;

  // A new operand may enter only if the result register is empty or draining.
  assign can_issue_c = !res_valid || res_ready;

  param_est_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .gnt_c (pick_c)
  );

  assign req_ready = (ap_rst_n && can_issue_c) ? pick_c : '0;
  assign gnt_any_c = |req_ready;

  // Operand mux driven by the one-hot grant.
  always_comb begin
    gnt_id_c = '0;
    op0_c    = '0;
    op1_c    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) begin
        gnt_id_c = ID_W'(i);
        op0_c    = req_din0[i*DIN0_W +: DIN0_W];
        op1_c    = req_din1[i*DIN1_W +: DIN1_W];
      end
    end
  end

  // Shared multiplier, zero pipeline stages; din1 is zero-extended to stay unsigned.
  assign prod_c = dout_t'(op0_c) * dout_t'($signed({1'b0, op1_c}));

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      res_valid <= 1'b0;
      res_dout  <= '0;
      res_id    <= '0;
      rr_ptr    <= '0;
      op_count  <= '0;
    end else begin
      if (gnt_any_c) begin
        res_valid <= 1'b1;
        res_dout  <= prod_c;
        res_id    <= gnt_id_c;
        rr_ptr    <= (gnt_id_c == ID_W'(N_REQ - 1)) ? '0 : gnt_id_c + ID_W'(1);
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
      if (res_valid && res_ready) begin
        op_count <= op_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_param_est_mul_share_arb.sv
// Directed bench for the shared-multiplier arbiter with a result scoreboard.
module tb_param_est_mul_share_arb;
  import param_est_mul_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic                     ap_clk = 1'b0;
  logic                     ap_rst_n;
  logic [N-1:0]             req_valid;
  logic [N-1:0]             req_ready;
  logic [N*DIN0_W-1:0]      req_din0;
  logic [N*DIN1_W-1:0]      req_din1;
  logic                     res_valid;
  logic                     res_ready;
  logic signed [DOUT_W-1:0] res_dout;
  logic [IW-1:0]            res_id;
  logic [31:0]              op_count;

  param_est_mul_share_arb #(.N_REQ(N), .ID_W(IW)) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_din0  (req_din0),
    .req_din1  (req_din1),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_dout  (res_dout),
    .res_id    (res_id),
    .op_count  (op_count)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct packed {
    logic [DOUT_W-1:0] dout;
    logic [IW-1:0]     id;
  } exp_t;

  int checks   = 0;
  int failures = 0;
  int d0 [N];
  int d1 [N];
  exp_t sb[$];

  logic              m_valid;
  logic [DOUT_W-1:0] m_dout;
  logic [IW-1:0]     m_id;
  logic [31:0]       m_cnt;
  int                m_ptr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] z29(input longint v);
    logic [DOUT_W-1:0] t;
    t = DOUT_W'(v);
    return {35'b0, t};
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < int'(N); k++) begin
      if (v[(ptr + k) % int'(N)]) return (ptr + k) % int'(N);
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_dout  = '0;
    m_id    = '0;
    m_cnt   = '0;
    m_ptr   = 0;
    sb.delete();
  endtask

  // One clock: check grant, push expectation, then check the registered result.
  task automatic cycle(input string tag);
    int          g;
    logic [N-1:0] exp_rdy;
    longint      p;
    exp_t        e;
    for (int i = 0; i < int'(N); i++) begin
      req_din0[i*DIN0_W +: DIN0_W] = DIN0_W'(d0[i]);
      req_din1[i*DIN1_W +: DIN1_W] = DIN1_W'(d1[i]);
    end
    #1;
    exp_rdy = '0;
    g       = -1;
    if (!m_valid || res_ready) g = pick(req_valid, m_ptr);
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk({tag, ":req_ready"}, 64'(req_ready), 64'(exp_rdy));
    if (g >= 0) begin
      p = longint'(d0[g]) * longint'(d1[g]);
      sb.push_back({DOUT_W'(p), IW'(g)});
      m_ptr = (g + 1) % int'(N);
    end
    @(posedge ap_clk);
    #1;
    if (m_valid && res_ready) m_cnt = m_cnt + 32'd1;
    if (g >= 0) begin
      e       = sb.pop_front();
      m_valid = 1'b1;
      m_dout  = e.dout;
      m_id    = e.id;
    end else if (res_ready) begin
      m_valid = 1'b0;
    end
    chk({tag, ":res_valid"}, 64'(res_valid), 64'(m_valid));
    chk({tag, ":res_dout"}, {35'b0, res_dout}, {35'b0, m_dout});
    chk({tag, ":res_id"}, 64'(res_id), 64'(m_id));
    chk({tag, ":op_count"}, 64'(op_count), 64'(m_cnt));
  endtask

  initial begin
    ap_rst_n  = 1'b0;
    req_valid = '1;
    res_ready = 1'b1;
    req_din0  = '0;
    req_din1  = '0;
    for (int i = 0; i < int'(N); i++) begin
      d0[i] = 0;
      d1[i] = 0;
    end
    model_reset();

    // Reset state, with all lanes requesting
    repeat (2) @(posedge ap_clk);
    #1;
    chk("rst:req_ready", 64'(req_ready), 64'(0));
    chk("rst:res_valid", 64'(res_valid), 64'(0));
    chk("rst:res_dout", {35'b0, res_dout}, 64'(0));
    chk("rst:res_id", 64'(res_id), 64'(0));
    chk("rst:op_count", 64'(op_count), 64'(0));
    req_valid = '0;
    ap_rst_n  = 1'b1;
    @(posedge ap_clk);
    #1;

    // Single lane
    d0[0] = -3; d1[0] = 4095;
    req_valid = 4'b0001;
    cycle("single");
    chk("single:const", {35'b0, res_dout}, 64'(29'h1FFFD003));

    // Drain with no new grant: data holds
    req_valid = '0;
    cycle("drain");

    // Operand extremes
    d0[2] = -32768; d1[2] = 8191;
    req_valid = 4'b0100;
    cycle("ext_neg");
    chk("ext_neg:const", {35'b0, res_dout}, z29(-64'sd268402688));
    d0[3] = 32767; d1[3] = 8191;
    req_valid = 4'b1000;
    cycle("ext_pos");
    chk("ext_pos:const", {35'b0, res_dout}, z29(64'sd268394497));

    // Round robin with all lanes valid
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < int'(N); i++) begin
        d0[i] = int'($urandom_range(65535)) - 32768;
        d1[i] = int'($urandom_range(8191));
      end
      cycle("rr");
      chk("rr:id_seq", 64'(res_id), 64'(c % int'(N)));
    end

    // Backpressure then release
    res_ready = 1'b0;
    for (int c = 0; c < 5; c++) cycle("stall");
    res_ready = 1'b1;
    cycle("release");

    // Asynchronous reset mid-stream
    ap_rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst:res_valid", 64'(res_valid), 64'(0));
    chk("arst:op_count", 64'(op_count), 64'(0));
    chk("arst:req_ready", 64'(req_ready), 64'(0));
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    req_valid = '1;
    cycle("post_rst");
    chk("post_rst:first_id", 64'(res_id), 64'(0));

    // Counter wrap
    req_valid = '0;
    force dut.op_count = 32'hFFFF_FFFF;
    #1;
    release dut.op_count;
    m_cnt = 32'hFFFF_FFFF;
    cycle("wrap");
    chk("wrap:const", 64'(op_count), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
